// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - time-multiplexed seven-segment driver for NUM_DIGITS hex digits
//
// Purpose:
//   Captures a packed hex value into a shadow register, scans the digit anodes
//   at a programmable refresh rate and drives the shared segment bus with the
//   0-F glyph of the selected digit. Supports per-digit decimal points,
//   leading-zero blanking and selectable pin polarity.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   value      packed hex digits, digit i = value[4i+3:4i], digit 0 least significant
//   load       capture value/dp into the shadow registers
//   dp         per-digit decimal point request
//   blank_lz   enable leading-zero suppression
//   enable     0 = display dark and scan frozen
//   seg        segments {a,b,c,d,e,f,g} = seg[6:0]
//   dp_out     decimal point segment
//   anode      one-hot digit select, bit i selects digit i
//   digit_idx  index of the currently selected digit

module hex_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [4*NUM_DIGITS-1:0]                              value,
  input  logic                                                 load,
  input  logic [NUM_DIGITS-1:0]                                dp,
  input  logic                                                 blank_lz,
  input  logic                                                 enable,
  output logic [6:0]                                           seg,
  output logic                                                 dp_out,
  output logic [NUM_DIGITS-1:0]                                anode,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // XOR mask applied to every pin: all ones flips the active-high form to active-low.
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  // Active-high glyph table, {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b1001110;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   dp_shadow;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;

  logic                    terminal;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic [6:0]              cur_glyph;

  assign terminal = (presc == PRE_LAST);
  assign next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Walk from the most significant digit down; a digit is blankable while every
  // nibble from it upward is zero. Digit 0 always stays lit.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (shadow[4*i +: 4] == 4'h0);
      blank_mask[i] = blank_lz && (i != 0) && zero_run;
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_onehot[i] = (idx == IDX_W'(i));
    end
  end

  assign cur_nib   = shadow[{idx, 2'b00} +: 4];
  assign cur_blank = blank_mask[idx];
  assign cur_dp    = dp_shadow[idx];
  assign cur_glyph = cur_blank ? 7'b0000000 : hex_glyph(cur_nib);

  // Shadow capture and scan timing. Load is independent of enable so the
  // value can be updated while the display is dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      dp_shadow <= '0;
      presc     <= '0;
      idx       <= '0;
    end else begin
      if (load) begin
        shadow    <= value;
        dp_shadow <= dp;
      end
      if (enable) begin
        if (terminal) begin
          presc <= '0;
          idx   <= next_idx;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Registered pins: one cycle behind the idx/shadow state they are built from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg       <= SEG_OFF;
      dp_out    <= POL;
      anode     <= AN_OFF;
      digit_idx <= '0;
    end else begin
      digit_idx <= idx;
      if (enable) begin
        seg    <= cur_glyph ^ SEG_OFF;
        dp_out <= cur_dp ^ POL;
        anode  <= sel_onehot ^ AN_OFF;
      end else begin
        seg    <= SEG_OFF;
        dp_out <= POL;
        anode  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb/tb_hex_scan_display.sv - randomized self-checking bench for hex_scan_display

module tb_hex_scan_display;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        enable;

  logic [6:0]  seg_h, seg_l;
  logic        dp_h, dp_l;
  logic [3:0]  an_h, an_l;
  logic [1:0]  idx_h, idx_l;

  int checks = 0;
  int errors = 0;

  // Reference state: shadow contents and number of enabled cycles since reset.
  logic [15:0] m_shadow;
  logic [3:0]  m_dp;
  int          ticks;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  always #5 clk = ~clk;

  hex_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp(dp),
    .blank_lz(blank_lz), .enable(enable),
    .seg(seg_h), .dp_out(dp_h), .anode(an_h), .digit_idx(idx_h)
  );

  hex_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp(dp),
    .blank_lz(blank_lz), .enable(enable),
    .seg(seg_l), .dp_out(dp_l), .anode(an_l), .digit_idx(idx_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inactive(input string tag);
    check({tag, "_seg"},    32'(seg_h), 32'h00);
    check({tag, "_dp"},     32'(dp_h),  32'h0);
    check({tag, "_anode"},  32'(an_h),  32'h0);
    check({tag, "_idx"},    32'(idx_h), 32'h0);
    check({tag, "_seg_l"},  32'(seg_l), 32'h7F);
    check({tag, "_dp_l"},   32'(dp_l),  32'h1);
    check({tag, "_anode_l"},32'(an_l),  32'hF);
  endtask

  // One clock: predict pins from the pre-edge state and inputs, advance the
  // reference, then compare shortly after the edge.
  task automatic step();
    int          cur;
    logic [15:0] rest;
    logic [6:0]  es, es_l;
    logic        ed, ed_l;
    logic [3:0]  ea, ea_l;
    cur  = (ticks / RD) % ND;
    rest = m_shadow >> (4 * cur);
    es = 7'd0;
    ed = 1'b0;
    ea = 4'd0;
    if (enable) begin
      es = (blank_lz && cur != 0 && rest == 16'd0) ? 7'd0 : glyph_tab[rest[3:0]];
      ed = m_dp[cur];
      ea = 4'(1 << cur);
    end
    es_l = ~es;
    ed_l = ~ed;
    ea_l = ~ea;
    if (load) begin
      m_shadow = value;
      m_dp     = dp;
    end
    if (enable) ticks++;
    @(posedge clk);
    #1;
    check("seg",     32'(seg_h), 32'(es));
    check("dp_out",  32'(dp_h),  32'(ed));
    check("anode",   32'(an_h),  32'(ea));
    check("idx",     32'(idx_h), 32'(cur));
    check("seg_l",   32'(seg_l), 32'(es_l));
    check("dp_l",    32'(dp_l),  32'(ed_l));
    check("anode_l", 32'(an_l),  32'(ea_l));
    check("idx_l",   32'(idx_l), 32'(cur));
  endtask

  // Called just after an edge: reset lands between edges and must act at once.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    check_inactive("rst_async");
    m_shadow = '0;
    m_dp     = '0;
    ticks    = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_run(input logic [15:0] v, input logic [3:0] d, input int n);
    value = v;
    dp    = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    logic [15:0] mask;
    reset    = 1'b1;
    value    = '0;
    load     = 1'b0;
    dp       = '0;
    blank_lz = 1'b0;
    enable   = 1'b0;
    m_shadow = '0;
    m_dp     = '0;
    ticks    = 0;
    #1;
    check_inactive("rst_init");
    repeat (2) @(posedge clk);
    #1;
    check_inactive("rst_held");
    reset  = 1'b0;
    enable = 1'b1;

    // First digit after release shows a zero on digit 0.
    step();
    check("rel_anode", 32'(an_h),  32'h1);
    check("rel_seg",   32'(seg_h), 32'h7E);

    // Plain scan, two full rotations.
    load_run(16'h3A5F, 4'b0000, 2 * ND * RD);

    // Leading-zero blanking on and off.
    blank_lz = 1'b1;
    load_run(16'h0007, 4'b0000, ND * RD + 2);
    load_run(16'h0000, 4'b0000, ND * RD + 2);
    load_run(16'h0070, 4'b1001, ND * RD + 2);
    blank_lz = 1'b0;
    load_run(16'h0007, 4'b0000, ND * RD + 2);

    // Decimal point on digit 2, then value churn without load.
    load_run(16'h1234, 4'b0100, ND * RD);
    repeat (ND * RD + 3) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      step();
    end

    // Freeze the scan partway through digit 2, then resume.
    load_run(16'h3A5F, 4'b0010, 0);
    for (int k = 0; k < 4 * ND * RD && !(((ticks / RD) % ND) == 2 && (ticks % RD) == 1); k++) step();
    enable = 1'b0;
    repeat (5) step();
    value = 16'hBEEF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    enable = 1'b1;
    repeat (ND * RD + 4) step();

    // Reset in the middle of a scan.
    mid_reset();
    enable = 1'b1;
    repeat (6) step();

    // Random traffic: sparse loads (often hitting terminal counts), short
    // enable drops, values biased toward leading zeros, occasional resets.
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 4))
        0: mask = 16'h0000;
        1: mask = 16'h000F;
        2: mask = 16'h00FF;
        3: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      value  = 16'($urandom) & mask;
      dp     = 4'($urandom);
      load   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 299) == 0) begin
        load = 1'b0;
        mid_reset();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
